// File: rtl/muldiv_seq_pkg.sv
// Shared encodings for the multi-cycle MULTU/DIVU sequencer: ALU control
// codes, controller states and the Op select values.
package muldiv_seq_pkg;

  // ALU control encodings understood by the shared 32-bit ALU
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // Op select as presented on the Op input
  localparam logic OP_MULTU = 1'b0;
  localparam logic OP_DIVU  = 1'b1;

  // Sequencer controller states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/muldiv_seq.sv
// Multi-cycle unsigned MULTU/DIVU sequencer for the HI/LO pair.
// While running it borrows the shared ALU: it drives AluCtrlOut/AluAOut/
// AluBOut combinationally from its own registers and consumes AluIn in the
// same cycle. One shift-add (MULTU) or restoring-division (DIVU) iteration
// is retired per RUN cycle, 32 iterations per operation.
//
// Handshake: Start is a request sampled only while IDLE; the accepting edge
// captures OpA/OpB/Op, so they need not be held afterwards. Busy is high for
// every non-IDLE cycle (32 RUN + 1 DONE) and Done pulses for the single DONE
// cycle, when Hi/Lo already hold the final result. Start seen in RUN or DONE
// is dropped with no side effects. The current state is visible on r_state.
//
// WIDTH must equal the ALU width; only 32 is supported (CNT_W = log2(WIDTH)).
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Start,
  input  logic             Op,
  input  logic [WIDTH-1:0] OpA,
  input  logic [WIDTH-1:0] OpB,
  output logic [2:0]       AluCtrlOut,
  output logic [WIDTH-1:0] AluAOut,
  output logic [WIDTH-1:0] AluBOut,
  input  logic [WIDTH-1:0] AluIn,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  state_e           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_bq;
  logic             r_op;
  logic             r_done;

  // Divide step: partial remainder shifted left with the next dividend bit.
  // The bit shifted out of r_hi is S[32]; when set, S always exceeds Bq.
  logic [WIDTH-1:0] w_shift;
  logic             w_ge;
  // Multiply step: carry-out of Hi + addend, recovered from the wrapped sum.
  logic             w_carry;
  logic [WIDTH-1:0] w_mul_hi;
  logic [WIDTH-1:0] w_mul_lo;
  logic [WIDTH-1:0] w_div_hi;
  logic [WIDTH-1:0] w_div_lo;
  logic [2:0]       w_alu_ctrl;
  logic [WIDTH-1:0] w_alu_a;
  logic [WIDTH-1:0] w_alu_b;

  assign w_shift  = {r_hi[WIDTH-2:0], r_lo[WIDTH-1]};
  assign w_ge     = r_hi[WIDTH-1] | (w_shift >= r_bq);
  assign w_carry  = (AluIn < r_hi);
  assign w_mul_hi = {w_carry, AluIn[WIDTH-1:1]};
  assign w_mul_lo = {AluIn[0], r_lo[WIDTH-1:1]};
  assign w_div_hi = w_ge ? AluIn : w_shift;
  assign w_div_lo = {r_lo[WIDTH-2:0], w_ge};

  // ALU request: idle as ADD 0+0, otherwise the current iteration's operands
  always_comb begin
    w_alu_ctrl = ALU_ADD;
    w_alu_a    = '0;
    w_alu_b    = '0;
    if (r_state == ST_RUN) begin
      if (r_op == OP_DIVU) begin
        w_alu_ctrl = ALU_SUB;
        w_alu_a    = w_shift;
        w_alu_b    = r_bq;
      end else begin
        w_alu_ctrl = ALU_ADD;
        w_alu_a    = r_hi;
        w_alu_b    = r_lo[0] ? r_bq : '0;
      end
    end
  end

  // Controller, iteration counter and HI/LO datapath in one sequential block
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_bq    <= '0;
      r_op    <= OP_MULTU;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (Start) begin
            r_lo    <= OpA;
            r_hi    <= '0;
            r_bq    <= OpB;
            r_op    <= Op;
            r_cnt   <= '0;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_op == OP_DIVU) begin
            r_hi <= w_div_hi;
            r_lo <= w_div_lo;
          end else begin
            r_hi <= w_mul_hi;
            r_lo <= w_mul_lo;
          end
          if (r_cnt == LAST_ITER) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign AluCtrlOut = w_alu_ctrl;
  assign AluAOut    = w_alu_a;
  assign AluBOut    = w_alu_b;
  assign Busy       = (r_state != ST_IDLE);
  assign Done       = r_done;
  assign Hi         = r_hi;
  assign Lo         = r_lo;

endmodule

// File: tb/tb_muldiv_seq.sv
// Bench for muldiv_seq: behavioural ALU, directed plus random MULTU/DIVU
// operations checked against an arithmetic reference model.
module tb_muldiv_seq;
  import muldiv_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        Start;
  logic        Op;
  logic [31:0] OpA;
  logic [31:0] OpB;
  logic [2:0]  AluCtrlOut;
  logic [31:0] AluAOut;
  logic [31:0] AluBOut;
  logic [31:0] AluIn;
  logic        Busy;
  logic        Done;
  logic [31:0] Hi;
  logic [31:0] Lo;

  int n_cmp = 0;
  int n_err = 0;
  logic [63:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  muldiv_seq #(.WIDTH(32), .CNT_W(5)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .Start      (Start),
    .Op         (Op),
    .OpA        (OpA),
    .OpB        (OpB),
    .AluCtrlOut (AluCtrlOut),
    .AluAOut    (AluAOut),
    .AluBOut    (AluBOut),
    .AluIn      (AluIn),
    .Busy       (Busy),
    .Done       (Done),
    .Hi         (Hi),
    .Lo         (Lo)
  );

  // Behavioural shared ALU
  always_comb begin
    case (AluCtrlOut)
      ALU_AND: AluIn = AluAOut & AluBOut;
      ALU_OR:  AluIn = AluAOut | AluBOut;
      ALU_ADD: AluIn = AluAOut + AluBOut;
      ALU_SUB: AluIn = AluAOut - AluBOut;
      ALU_SLT: AluIn = {31'b0, ($signed(AluAOut) < $signed(AluBOut))};
      default: AluIn = 32'h0;
    endcase
  end

  // ---------------- reference model ----------------
  function automatic logic [63:0] ref_model(input logic op, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [63:0] a64;
    logic [63:0] b64;
    a64 = {32'h0, a};
    b64 = {32'h0, b};
    if (op == OP_MULTU) return a64 * b64;
    if (b == 32'h0) return {a, 32'hFFFF_FFFF};
    return {a % b, a / b};
  endfunction

  // ---------------- checker ----------------
  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Called at a negedge with the DUT idle; returns at a negedge with it idle.
  task automatic run_op(input string tag, input logic op, input logic [31:0] a,
                        input logic [31:0] b, input bit inj_run10, input bit inj_done);
    int busy_cnt;
    int done_cnt;
    int done_at;
    int i;
    logic [63:0] exp;
    Start = 1'b1; Op = op; OpA = a; OpB = b;
    exp_q.push_back(ref_model(op, a, b));
    @(negedge clk);
    // Scramble operands after the accepting edge: must have no effect
    Start = 1'b0; Op = 1'($urandom); OpA = $urandom; OpB = $urandom;
    busy_cnt = 0; done_cnt = 0; done_at = 0; i = 0;
    while (Busy && i < 40) begin
      busy_cnt++;
      if (Done) begin
        done_cnt++;
        done_at = busy_cnt;
      end
      if (inj_run10 && i == 10) Start = 1'b1;
      else if (inj_done && Done) Start = 1'b1;
      else Start = 1'b0;
      @(negedge clk);
      i++;
    end
    Start = 1'b0;
    check_val({tag, " timeout"}, 64'(i < 40), 64'd1);
    check_val({tag, " busy_cycles"}, 64'(busy_cnt), 64'd33);
    check_val({tag, " done_pulses"}, 64'(done_cnt), 64'd1);
    check_val({tag, " done_cycle"}, 64'(done_at), 64'd33);
    if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      check_val({tag, " hi"}, 64'(Hi), 64'(exp[63:32]));
      check_val({tag, " lo"}, 64'(Lo), 64'(exp[31:0]));
    end
    check_val({tag, " idle_ctrl"}, 64'({AluCtrlOut, AluAOut, AluBOut}), 64'({ALU_ADD, 64'h0}));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic        r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;
    rst_n = 1'b0; Start = 1'b0; Op = 1'b0; OpA = '0; OpB = '0;
    repeat (3) @(negedge clk);
    check_val("rst busy_done", 64'({Busy, Done}), 64'd0);
    check_val("rst hi_lo", {Hi, Lo}, 64'd0);
    check_val("rst alu", 64'({AluCtrlOut, AluAOut, AluBOut}), 64'({ALU_ADD, 64'h0}));
    rst_n = 1'b1;
    @(negedge clk);

    run_op("mul7x6",   OP_MULTU, 32'd7,          32'd6,          1'b0, 1'b0);
    run_op("mulmax",   OP_MULTU, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0, 1'b0);
    run_op("div100_7", OP_DIVU,  32'd100,        32'd7,          1'b0, 1'b0);
    run_op("div8m_3",  OP_DIVU,  32'h8000_0000,  32'd3,          1'b0, 1'b0);
    run_op("div_s32",  OP_DIVU,  32'hFFFF_FFFF,  32'h8000_0001,  1'b0, 1'b0);
    run_op("div_zero", OP_DIVU,  32'h1234_5678,  32'h0,          1'b0, 1'b0);
    // Starts during RUN cycle 10 and the DONE cycle are dropped; the next
    // op is launched in the very first IDLE cycle after DONE.
    run_op("ign_start", OP_MULTU, 32'hDEAD_BEEF, 32'h0000_1234,  1'b1, 1'b1);
    run_op("next_idle", OP_DIVU,  32'hCAFE_F00D, 32'h0000_0101,  1'b0, 1'b0);

    // Asynchronous reset in RUN cycle 15
    Start = 1'b1; Op = OP_MULTU; OpA = 32'hFFFF_0000; OpB = 32'h0001_FFFF;
    @(negedge clk);
    Start = 1'b0;
    repeat (15) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_val("abort busy_done", 64'({Busy, Done}), 64'd0);
    check_val("abort hi_lo", {Hi, Lo}, 64'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_val("abort no_done", 64'({Busy, Done}), 64'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    run_op("mul3x5", OP_MULTU, 32'd3, 32'd5, 1'b0, 1'b0);

    // Random operations
    for (int n = 0; n < 24; n++) begin
      r_op = 1'($urandom);
      case ($urandom_range(0, 3))
        0:       r_a = $urandom_range(0, 255);
        default: r_a = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0:       r_b = 32'h0;
        1:       r_b = $urandom_range(1, 15);
        default: r_b = $urandom;
      endcase
      run_op("rand", r_op, r_a, r_b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    check_val("scoreboard empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
